// File: rtl/qbus_dl11.sv
// qbus_dl11 - QBUS console terminal slave (DL11 subset).
//
// Decodes a four-register block (RCSR/RBUF/XCSR/XBUF) at BASE on the
// inverted AD bus, replies to DIN/DOUT cycles with RPLY, and supplies the
// receiver/transmitter vectors during interrupt-acknowledge cycles.
//
// Ports:
//   clk, init             clock, synchronous active-high reset
//   ad_in_n / ad_out_n    inverted AD bus in / inverted data or vector out
//   ad_oe                 AD output enable
//   sync_n, din_n, dout_n, wtbt_n, iako_n   bus control inputs (active low)
//   rply_n, virq_n        reply and vectored interrupt request (active low)
//   tx_data/tx_valid/tx_ready   transmit byte handshake toward a sink
//   rx_data/rx_valid      received byte strobe from a source
module qbus_dl11 #(
    parameter logic [15:0] BASE   = 16'o177560,
    parameter logic [15:0] VEC_RX = 16'o000060,
    parameter logic [15:0] VEC_TX = 16'o000064
) (
    input  logic        clk,
    input  logic        init,
    input  logic [15:0] ad_in_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    input  logic        sync_n,
    input  logic        din_n,
    input  logic        dout_n,
    input  logic        wtbt_n,
    input  logic        iako_n,
    output logic        rply_n,
    output logic        virq_n,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_READ, S_WRITE, S_VECT, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic        sync_q;
    logic [2:0]  addr;
    logic        sel;

    logic        rx_done, rx_ie, tx_rdy, tx_ie;
    logic [7:0]  rbuf;
    logic        rx_req, tx_req, rx_term_q, tx_term_q;

    logic        sync_fall, rd_cap, vec_cap, wr_do;
    logic        reg_wr, xbuf_load, rbuf_rd, tx_hs;
    logic        rx_term, tx_term, rx_ack, tx_ack;
    logic [7:0]  wr_byte;
    logic [15:0] rd_data;

    // Next-state and single-cycle strobes for the datapath.
    always_comb begin
        state_nx  = state;
        rd_cap    = 1'b0;
        vec_cap   = 1'b0;
        wr_do     = 1'b0;
        sync_fall = sync_q & ~sync_n;
        case (state)
            S_IDLE:
                if (sync_fall)
                    state_nx = S_ADDR;
                else if (!iako_n && !din_n && sync_n && (rx_req || tx_req))
                    state_nx = S_VECT;
            S_ADDR:
                if (sync_n)
                    state_nx = S_IDLE;
                else if (sel && !din_n)
                    state_nx = S_READ;
                else if (sel && !dout_n)
                    state_nx = S_WRITE;
            S_READ:
                if (din_n) state_nx = S_DONE;
                else       rd_cap = ~ad_oe;
            S_VECT:
                if (din_n) state_nx = S_DONE;
                else       vec_cap = ~ad_oe;
            S_WRITE:
                if (dout_n) state_nx = S_DONE;
                else        wr_do = rply_n;
            S_DONE:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        rd_data = '0;
        case (addr[2:1])
            2'd0: rd_data = {8'h00, rx_done, rx_ie, 6'b0};
            2'd1: rd_data = {8'h00, rbuf};
            2'd2: rd_data = {8'h00, tx_rdy, tx_ie, 6'b0};
            2'd3: rd_data = '0;
            default: rd_data = '0;
        endcase
    end

    // An odd-address byte write targets the high byte, which holds nothing.
    assign wr_byte   = ~ad_in_n[7:0];
    assign reg_wr    = wr_do & ~(~wtbt_n & addr[0]);
    assign tx_hs     = tx_valid & tx_ready;
    // A handshake completing on the write edge frees the buffer in time.
    assign xbuf_load = reg_wr && (addr[2:1] == 2'd3) && (tx_rdy || tx_hs);
    assign rbuf_rd   = rd_cap && (addr[2:1] == 2'd1);

    assign rx_term = rx_done & rx_ie;
    assign tx_term = tx_rdy & tx_ie;
    assign rx_ack  = vec_cap & rx_req;
    assign tx_ack  = vec_cap & ~rx_req & tx_req;
    assign virq_n  = ~(rx_req | tx_req);

    always_ff @(posedge clk) begin
        if (init) begin
            sync_q    <= 1'b1;
            addr      <= '0;
            sel       <= 1'b0;
            rply_n    <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out_n  <= '1;
            rx_done   <= 1'b0;
            rx_ie     <= 1'b0;
            rbuf      <= '0;
            tx_rdy    <= 1'b1;
            tx_ie     <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            rx_req    <= 1'b0;
            tx_req    <= 1'b0;
            rx_term_q <= 1'b0;
            tx_term_q <= 1'b0;
        end else begin
            sync_q <= sync_n;
            if (state == S_IDLE && sync_fall) begin
                addr <= ~ad_in_n[2:0];
                sel  <= (~ad_in_n[15:3] == BASE[15:3]);
            end

            // Bus outputs: data goes out one cycle ahead of the reply.
            if (state == S_DONE) begin
                rply_n   <= 1'b1;
                ad_oe    <= 1'b0;
                ad_out_n <= '1;
            end else if (rd_cap) begin
                ad_oe    <= 1'b1;
                ad_out_n <= ~rd_data;
            end else if (vec_cap) begin
                ad_oe    <= 1'b1;
                ad_out_n <= rx_req ? ~VEC_RX : ~VEC_TX;
            end else if ((state == S_READ || state == S_VECT) && !din_n && ad_oe) begin
                rply_n <= 1'b0;
            end else if (wr_do) begin
                rply_n <= 1'b0;
            end

            // A byte arriving with an RBUF read keeps DONE set.
            if (rx_valid) begin
                rbuf    <= rx_data;
                rx_done <= 1'b1;
            end else if (rbuf_rd) begin
                rx_done <= 1'b0;
            end

            if (reg_wr && addr[2:1] == 2'd0) rx_ie <= wr_byte[6];
            if (reg_wr && addr[2:1] == 2'd2) tx_ie <= wr_byte[6];

            if (xbuf_load) begin
                tx_data  <= wr_byte;
                tx_valid <= 1'b1;
                tx_rdy   <= 1'b0;
            end else if (tx_hs) begin
                tx_valid <= 1'b0;
                tx_rdy   <= 1'b1;
            end

            // Requests arm on a rising term and drop on ack or falling term.
            rx_term_q <= rx_term;
            tx_term_q <= tx_term;
            if (!rx_term)                rx_req <= 1'b0;
            else if (!rx_term_q)         rx_req <= 1'b1;
            else if (rx_ack)             rx_req <= 1'b0;
            if (!tx_term)                tx_req <= 1'b0;
            else if (!tx_term_q)         tx_req <= 1'b1;
            else if (tx_ack)             tx_req <= 1'b0;
        end
    end

endmodule

// File: doc/qbus_dl11.md
# qbus_dl11

Synthesizable QBUS console terminal slave (DL11 subset) decoding addresses 177560–177566 on the inverted-AD bus of the am4 core. It latches the address on `sync_n`, answers `din_n`/`dout_n` with `rply_n`, and raises `virq_n`. It returns vectors 060 (receiver) and 064 (transmitter) during `iako_n` cycles. The byte side connects to a UART or simulation sink/source through ready/valid handshakes.

## Interface

**Parameters**
- `BASE`, 16'o177560: register block base address; must be 8-byte aligned.
- `VEC_RX`, 16'o000060: receiver interrupt vector.
- `VEC_TX`, 16'o000064: transmitter interrupt vector.

**Ports**
- `clk` in 1: clock. All bus pins are sampled on its rising edge.
- `init` in 1: synchronous active-high reset.
- `ad_in_n` in 16: inverted AD bus as seen on the pins.
- `ad_out_n` out 16: inverted data/vector to drive onto AD.
- `ad_oe` out 1: AD output enable.
- `sync_n` in 1: address strobe, active low.
- `din_n` in 1: data input strobe, active low.
- `dout_n` in 1: data output strobe, active low.
- `wtbt_n` in 1: write/byte status, active low.
- `iako_n` in 1: interrupt acknowledge, active low.
- `rply_n` out 1: transaction reply, active low.
- `virq_n` out 1: vectored interrupt request, active low.
- `tx_data` out 8: transmit byte.
- `tx_valid` out 1: transmit byte valid.
- `tx_ready` in 1: sink accepts byte.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: received byte strobe, one cycle.

## Operation

**Registers** (address = `BASE` + offset)
- +0 RCSR: bit7 DONE (read-only), bit6 IE (read/write); all other bits read 0.
- +2 RBUF: bits 7:0 hold the last received byte. A read clears DONE. Writes are ignored.
- +4 XCSR: bit7 RDY (read-only), bit6 IE (read/write).
- +6 XBUF: reads 0. A low-byte write with RDY=1 loads `tx_data`, sets `tx_valid`, and clears RDY. A write with RDY=0 is dropped but still replied.
- Odd-address byte writes (`wtbt_n` low in the data phase, `a[0]`=1) change nothing.
- Even-address byte writes act as word writes of bits 7:0.

**Bus FSM** (states IDLE, ADDR, READ, WRITE, VECT, DONE)
- IDLE → ADDR when `sync_n` goes 1→0. The block latches `~ad_in_n` into `addr` and sets `sel` = (`addr[15:3]` == `BASE[15:3]`).
- ADDR → READ when `din_n` is low and `sel`=1.
- ADDR → WRITE when `dout_n` is low and `sel`=1.
- ADDR → IDLE when `sync_n` goes high.
- READ: drives `ad_out_n` = ~data and `ad_oe`=1. Asserts `rply_n`=0 one cycle later.
- WRITE: captures `~ad_in_n` on the first cycle `dout_n` is seen low, then asserts `rply_n`=0.
- IDLE → VECT when `iako_n`=0, `din_n`=0, `sync_n`=1 and a request is pending.
  - The vector goes out on the next cycle.
  - The RX request wins over TX. The selected request flag clears.
- READ, WRITE, VECT → DONE when the strobe returns high. In DONE, `rply_n` and `ad_oe` deassert on the same edge, then the FSM returns to IDLE.
- Unselected cycles never drive `rply_n` or `ad_oe`.

**Data side**
- `rx_valid` latches `rx_data` and sets DONE. A new byte overwrites an unread byte.
- `tx_valid` && `tx_ready` clears `tx_valid` and sets RDY.

**Interrupts**
- `rx_req` sets on the rising edge of (DONE & RCSR.IE). It clears on RX vector acknowledge or when that term falls.
- `tx_req` behaves the same way for (RDY & XCSR.IE).
- `virq_n` = ~(`rx_req` | `tx_req`).

## Timing

**Reset values**
- `ad_oe`=0, `ad_out_n`=16'hFFFF, `rply_n`=1, `virq_n`=1, `tx_valid`=0, `tx_data`=0.
- DONE=0, RDY=1, both IE=0, both request flags 0, FSM=IDLE.
- `init` asserted mid-transaction forces IDLE and releases `rply_n`/`ad_oe` on the next edge.

**Latencies**
- Read: `rply_n` falls 2 clocks after the first clock edge on which the strobe is sampled low.
- Write: register update is visible 1 clock after `dout_n` is sampled low. `rply_n` falls on the same edge.
- Vector: same latency as a read.
- Release: `rply_n` rises 1 clock after the strobe is sampled high.

**Ordering and simultaneous events**
- Data output is valid on AD at least 1 clock before `rply_n` falls.
- `rx_valid` in the same cycle as an RBUF read: the read returns the old byte, and DONE ends set.
- `tx_ready` in the same cycle as an XBUF write: the handshake completes first, so the write is accepted.
- Setting XCSR.IE while RDY=1 raises `virq_n`=0 one cycle after the write.

## Test plan

- Reset, then read 177564 → data 000200, `rply_n` low 2 clocks after `din_n` low; read 177560 → 000000.
- Write 000101 to 177566 → `tx_data`=8'o101, `tx_valid`=1, XCSR reads 000000. Hold `tx_ready`=0 and write 000102 → dropped. Pulse `tx_ready` → RDY=1.
- Pulse `rx_valid` with 8'h5A → RCSR reads 000200. Read 177562 → 000132. RCSR then reads 000000.
- Write 000100 to 177564 with RDY=1 → `virq_n`=0. IAKO+DIN cycle → AD carries ~000064, `rply_n` low, `virq_n` returns high.
- Both requests pending (RCSR.IE=XCSR.IE=1, DONE=RDY=1) → first IAKO returns 000060, second returns 000064.
- Access 177570 and 001000 → no `rply_n`, `ad_oe` stays 0. Assert `init` during a READ → `rply_n`=1 and `ad_oe`=0 on the next clock.
